pc_branch_unit: RTL and testbench

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

---
 rtl/pc_branch_unit_pkg.sv | 35 +++
 rtl/pc_branch_unit_target_adder.sv | 17 +
 rtl/pc_branch_unit.sv | 126 ++++++++++++
 tb/tb_pc_branch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared types for the PC / branch unit: FSM states, branch
// condition codes and the sequential PC increment.
package pc_branch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BR_EQ = 2'd0,
    BR_NE = 2'd1,
    BR_LT = 2'd2,
    BR_GE = 2'd3
  } br_cond_e;

  localparam int unsigned PC_INC = 4;

  function automatic logic cond_ok(
    input logic [1:0] c,
    input logic       eq,
    input logic       lt
  );
    logic r;
    unique case (br_cond_e'(c))
      BR_EQ: r = eq;
      BR_NE: r = !eq;
      BR_LT: r = lt;
      BR_GE: r = !lt;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_branch_unit_target_adder.sv
// Branch target: pc plus the scaled offset, modulo 2^XLEN.
// Offset bits shifted past the MSB are dropped.
module pc_target_adder #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned OFFSET_SHIFT = 2
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] extension,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] offset;

  assign offset = extension << OFFSET_SHIFT;
  assign target = pc + offset;

endmodule

// File: rtl/pc_branch_unit.sv
// PC register, branch/jump redirect and BOOT/RUN/HALT control.
// Define PC_BRANCH_STATS_EN to add branch statistics counters.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int unsigned    XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned    OFFSET_SHIFT = 2,
  parameter int unsigned    CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  input  logic            branch,
  input  logic [1:0]      br_cond,
  input  logic            eq,
  input  logic            lt,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] extension,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            taken,
  output logic            fetch_valid
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
`endif
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] seq_pc;
  logic            fv_q, fv_d;
  logic            cond_hit;
  logic            run_ok;

  assign cond_hit = cond_ok(br_cond, eq, lt);
  assign run_ok   = (state_q == RUN) && !stall;
  assign taken    = run_ok && (jump || (branch && cond_hit));
  assign seq_pc   = pc_q + XLEN'(PC_INC);

  pc_target_adder #(
    .XLEN        (XLEN),
    .OFFSET_SHIFT(OFFSET_SHIFT)
  ) u_adder (
    .pc       (pc_q),
    .extension(extension),
    .target   (br_target)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt) state_d = HALT;
      HALT:    if (resume && !halt) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // The halting edge also freezes pc, so it is treated as a hold.
  always_comb begin
    next_pc = seq_pc;
    priority case (1'b1)
      state_q == BOOT:                    next_pc = RESET_PC;
      state_q != RUN || stall || halt:    next_pc = pc_q;
      jump:                               next_pc = jump_target;
      branch && cond_hit:                 next_pc = br_target;
      default:                            next_pc = seq_pc;
    endcase
  end

  assign fv_d = (state_d == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= next_pc;
      fv_q    <= fv_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fv_q;

`ifdef PC_BRANCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (run_ok && branch) begin
      if (br_cnt_q != CNT_MAX)
        br_cnt_d = br_cnt_q + CNT_W'(1);
      if (cond_hit && tk_cnt_q != CNT_MAX)
        tk_cnt_d = tk_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign br_count    = br_cnt_q;
  assign taken_count = tk_cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_pc_branch_unit;

  localparam logic [31:0] RPC    = 32'h100;
  localparam int          SH     = 2;
  localparam int          CW     = 2;
  localparam int          CMAX   = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst, stall, halt, resume, branch, eq, lt, jump;
  logic [1:0]  br_cond;
  logic [31:0] jump_target, extension;
  logic [31:0] pc, next_pc;
  logic        taken, fetch_valid;
`ifdef PC_BRANCH_STATS_EN
  logic [CW-1:0] br_count, taken_count;
`endif

  pc_branch_unit #(
    .XLEN(32), .RESET_PC(RPC), .OFFSET_SHIFT(SH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .resume(resume), .branch(branch), .br_cond(br_cond),
    .eq(eq), .lt(lt), .jump(jump), .jump_target(jump_target),
    .extension(extension), .pc(pc), .next_pc(next_pc),
    .taken(taken), .fetch_valid(fetch_valid)
`ifdef PC_BRANCH_STATS_EN
    , .br_count(br_count), .taken_count(taken_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 = BOOT, 1 = RUN, 2 = HALT
  int          m_st;
  logic [31:0] m_pc;
  int          m_br, m_tk;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit m_cond();
    case (br_cond)
      2'd0:    return eq;
      2'd1:    return !eq;
      2'd2:    return lt;
      default: return !lt;
    endcase
  endfunction

  task automatic m_reset();
    m_st = 0;
    m_pc = RPC;
    m_br = 0;
    m_tk = 0;
  endtask

  task automatic idle();
    stall = 0; halt = 0; resume = 0; branch = 0;
    br_cond = 0; eq = 0; lt = 0; jump = 0;
    jump_target = 0; extension = 0;
  endtask

  // Check outputs against the model, then take one clock edge.
  task automatic cycle();
    logic [31:0] e_next;
    bit          e_tk, c, live;
    #1;
    c    = m_cond();
    live = (m_st == 1) && !stall;
    e_tk = live && (jump || (branch && c));
    if (m_st == 0)                       e_next = RPC;
    else if (m_st != 1 || stall || halt) e_next = m_pc;
    else if (jump)                       e_next = jump_target;
    else if (branch && c)                e_next = m_pc + (extension << SH);
    else                                 e_next = m_pc + 32'd4;
    chk("pc", pc, m_pc);
    chk("fetch_valid", fetch_valid, (m_st == 1));
    chk("taken", taken, e_tk);
    chk("next_pc", next_pc, e_next);
`ifdef PC_BRANCH_STATS_EN
    chk("br_count", br_count, m_br);
    chk("taken_count", taken_count, m_tk);
`endif
    @(posedge clk);
    m_pc = e_next;
    if (live && branch) begin
      if (m_br < CMAX) m_br++;
      if (c && m_tk < CMAX) m_tk++;
    end
    case (m_st)
      0:       m_st = 1;
      1:       if (halt) m_st = 2;
      default: if (!halt && resume) m_st = 1;
    endcase
    #1;
  endtask

  task automatic goto(logic [31:0] a);
    idle();
    jump = 1;
    jump_target = a;
    cycle();
    idle();
  endtask

  typedef struct {
    logic [31:0] start;
    logic        br;
    logic [1:0]  c;
    logic        e, l, j;
    logic [31:0] jt, ext;
    logic        exp_tk;
    logic [31:0] exp_nx;
  } vec_t;

  vec_t vecs[9];
  int   br0, tk0;

  initial begin
    vecs[0] = '{32'h200, 1, 2'd0, 1, 0, 0, 32'h0, 32'hFFFF_FFFE, 1, 32'h1F8};
    vecs[1] = '{32'h200, 1, 2'd0, 1, 0, 1, 32'h40, 32'h8, 1, 32'h40};
    vecs[2] = '{32'hFFFF_FFFC, 0, 2'd0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0};
    vecs[3] = '{32'h1000, 1, 2'd1, 1, 0, 0, 32'h0, 32'h10, 0, 32'h1004};
    vecs[4] = '{32'h1000, 1, 2'd2, 0, 1, 0, 32'h0, 32'h4, 1, 32'h1010};
    vecs[5] = '{32'h1000, 1, 2'd3, 0, 1, 0, 32'h0, 32'h4, 0, 32'h1004};
    vecs[6] = '{32'h1000, 1, 2'd3, 0, 0, 0, 32'h0, 32'h4000_0001, 1, 32'h1004};
    vecs[7] = '{32'hFFFF_FFF0, 1, 2'd0, 1, 0, 0, 32'h0, 32'h8, 1, 32'h10};
    vecs[8] = '{32'h1000, 1, 2'd1, 0, 0, 0, 32'h0, 32'h3, 1, 32'h100C};

    idle();
    rst = 1;
    m_reset();
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_fv", fetch_valid, 0);
    @(posedge clk);
    #1;
    rst = 0;

    // Reset release: BOOT cycle, then RESET_PC fetchable, then +4
    #1;
    chk("boot_pc", pc, 32'h100);
    chk("boot_fv", fetch_valid, 0);
    cycle();
    chk("run0_pc", pc, 32'h100);
    chk("run0_fv", fetch_valid, 1);
    cycle();
    chk("run1_pc", pc, 32'h104);

    foreach (vecs[i]) begin
      goto(vecs[i].start);
      branch = vecs[i].br;
      br_cond = vecs[i].c;
      eq = vecs[i].e;
      lt = vecs[i].l;
      jump = vecs[i].j;
      jump_target = vecs[i].jt;
      extension = vecs[i].ext;
      #1;
      chk($sformatf("vec%0d_taken", i), taken, vecs[i].exp_tk);
      chk($sformatf("vec%0d_next", i), next_pc, vecs[i].exp_nx);
      cycle();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_nx);
    end

    // Stall holds pc and suppresses redirect and counting
    goto(32'h300);
    br0 = m_br;
    tk0 = m_tk;
    stall = 1; branch = 1; br_cond = 0; eq = 1; extension = 4;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_taken", taken, 0);
      cycle();
      chk("stall_pc", pc, 32'h300);
    end
`ifdef PC_BRANCH_STATS_EN
    chk("stall_brc", br_count, br0);
    chk("stall_tkc", taken_count, tk0);
`endif
    stall = 0;
    cycle();
    chk("unstall_pc", pc, 32'h310);

    // Halt, wait, halt-over-resume, resume
    idle();
    halt = 1;
    cycle();
    chk("halt_pc", pc, 32'h310);
    chk("halt_fv", fetch_valid, 0);
    halt = 0;
    cycle();
    cycle();
    halt = 1; resume = 1;
    cycle();
    chk("halt_prio_fv", fetch_valid, 0);
    halt = 0;
    cycle();
    chk("resume_fv", fetch_valid, 1);
    resume = 0;
    cycle();
    chk("resume_pc", pc, 32'h314);

    // Async reset while in HALT with a pending jump
    halt = 1;
    cycle();
    halt = 0; resume = 0; jump = 1; jump_target = 32'h7000;
    #2;
    rst = 1;
    #1;
    m_reset();
    chk("arst_pc", pc, RPC);
    chk("arst_fv", fetch_valid, 0);
    chk("arst_state", dut.state_q, 2'd0);
    @(posedge clk);
    #1;
    rst = 0;
    idle();
    #1;
    chk("arst_state2", dut.state_q, 2'd0);
    chk("arst_next", next_pc, RPC);
    cycle();
    chk("arst_run_pc", pc, RPC);

    // Five taken branches against a 2-bit saturating counter
    branch = 1; br_cond = 0; eq = 1; extension = 1;
    for (int k = 0; k < 5; k++) cycle();
`ifdef PC_BRANCH_STATS_EN
    chk("sat_tkc", taken_count, 3);
    chk("sat_brc", br_count, 3);
`endif
    chk("sat_pc", pc, RPC + 32'd20);

    // Randomized run against the model
    for (int k = 0; k < 3000; k++) begin
      stall = ($urandom_range(3) == 0);
      halt = ($urandom_range(15) == 0);
      resume = $urandom_range(1);
      branch = $urandom_range(1);
      br_cond = 2'($urandom_range(3));
      eq = $urandom_range(1);
      lt = $urandom_range(1);
      jump = ($urandom_range(7) == 0);
      jump_target = $urandom() & 32'hFFFF_FFFC;
      extension = $urandom_range(1) ? $urandom()
                                    : 32'($signed(8'($urandom())));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
